input_debouncer: RTL and testbench

- Conditions a noisy, asynchronous 1-bit input (push-button or switch) into a clean, clock-synchronous level plus single-cycle edge pulses.
- Sits directly upstream of the team's dff storage stage: level or rise drives the flop's d input.
- Flow: synchronizer chain, then a stability-counting FSM, then registered outputs.

---
 rtl/input_debouncer.sv | 118 +++++++++++
 tb/tb_input_debouncer.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/input_debouncer.sv
// input_debouncer: turns a noisy asynchronous 1-bit input into a clean,
// clock-synchronous level with single-cycle rise/fall pulses.
// Path: raw_in -> synchronizer chain -> stability-counting FSM -> output flops.
//
// Handshake note: this block has no valid/ready flow control. rise and fall
// are single-cycle strobes that are valid in the cycle after the clock edge
// that changed level. busy is high exactly while the FSM sits in CHECK.
module input_debouncer #(
  parameter int       SYNC_STAGES   = 2,
  parameter int       CNT_W         = 4,
  parameter int       STABLE_CYCLES = 10,
  parameter logic     RESET_LEVEL   = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             raw_in,
  input  logic             en,
  output logic             level,
  output logic             levelb,
  output logic             rise,
  output logic             fall,
  output logic             busy,
  output logic             dbg_state,
  output logic [CNT_W-1:0] dbg_cnt
);

  typedef enum logic {
    STABLE = 1'b0,
    CHECK  = 1'b1
  } state_t;

  // Terminal count: the last sample of a disagreeing run toggles level.
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   toggle;

  assign sync = sync_q[SYNC_STAGES-1];

  // Synchronizer shift chain; runs every cycle, independent of en.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{RESET_LEVEL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in};
    end
  end

  // FSM state and stability counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= STABLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: STABLE watches for disagreement every cycle; CHECK
  // counts enabled disagreeing samples and rejects any agreeing sample.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    toggle  = 1'b0;
    case (state_q)
      STABLE: begin
        if (sync != level) begin
          state_d = CHECK;
          cnt_d   = '0;
        end
      end
      CHECK: begin
        if (en) begin
          if (sync == level) begin
            state_d = STABLE;
            cnt_d   = '0;
          end else if (cnt_q == LAST) begin
            toggle  = 1'b1;
            state_d = STABLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Registered outputs; busy is loaded from the next state so it always
  // equals (state == CHECK) in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level  <= RESET_LEVEL;
      levelb <= ~RESET_LEVEL;
      rise   <= 1'b0;
      fall   <= 1'b0;
      busy   <= 1'b0;
    end else begin
      level  <= level ^ toggle;
      levelb <= ~(level ^ toggle);
      rise   <= toggle & ~level;
      fall   <= toggle & level;
      busy   <= (state_d == CHECK);
    end
  end

  assign dbg_state = state_q;
  assign dbg_cnt   = cnt_q;

endmodule

// File: tb/tb_input_debouncer.sv
// Bench for input_debouncer: directed scenarios push per-edge expected
// {level, levelb, rise, fall, busy} vectors into a queue; a monitor pops
// and compares one entry after each rising edge.
module tb_input_debouncer;

  logic       clk;
  logic       clk_run;
  logic       reset;
  logic       raw_in;
  logic       en;
  logic       level;
  logic       levelb;
  logic       rise;
  logic       fall;
  logic       busy;
  logic       dbg_state;
  logic [3:0] dbg_cnt;

  logic [4:0] exp_q[$];
  string      tag_q[$];

  int tests;
  int failed;

  input_debouncer dut (
    .clk       (clk),
    .reset     (reset),
    .raw_in    (raw_in),
    .en        (en),
    .level     (level),
    .levelb    (levelb),
    .rise      (rise),
    .fall      (fall),
    .busy      (busy),
    .dbg_state (dbg_state),
    .dbg_cnt   (dbg_cnt)
  );

  // Clock / reset block: clock is held idle until clk_run is set.
  initial begin
    clk = 1'b0;
    forever begin
      #5;
      if (clk_run) clk = ~clk;
    end
  end

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got {lvl,lvlb,rise,fall,busy}=%b expected %b", name, act, exp);
    end
  endtask

  // Driver: n edges; raw_in = raw_val for edges 1..raw_len, then back to lvl0.
  // en is high on edges that are multiples of en_per. busy expected high on
  // edges [bf, bt); level toggles on edge tog (0 = never).
  task automatic run(input string tag, input int n, input logic raw_val, input int raw_len,
                     input int en_per, input logic lvl0, input int bf, input int bt,
                     input int tog);
    logic lvl;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      raw_in = (k <= raw_len) ? raw_val : lvl0;
      en     = ((k % en_per) == 0);
      lvl    = (tog > 0 && k >= tog) ? ~lvl0 : lvl0;
      exp_q.push_back({lvl, ~lvl, (k == tog) && !lvl0, (k == tog) && lvl0,
                       (k >= bf) && (k < bt)});
      tag_q.push_back($sformatf("%s_e%0d", tag, k));
    end
  endtask

  // Scoreboard monitor: compare DUT outputs 1 time unit after each edge.
  initial begin
    logic [4:0] e;
    string      t;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check(t, {level, levelb, rise, fall, busy}, e);
      end
    end
  end

  initial begin
    tests   = 0;
    failed  = 0;
    clk_run = 1'b0;
    reset   = 1'b0;
    raw_in  = 1'bx;
    en      = 1'b1;

    // Asynchronous reset with the clock idle.
    #2 reset = 1'b1;
    #1 check("reset_async", {level, levelb, rise, fall, busy}, 5'b01000);

    raw_in  = 1'b0;
    clk_run = 1'b1;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;

    run("rise",    16, 1'b1, 16, 1, 1'b0, 3, 13, 13);
    run("fall",    16, 1'b0, 16, 1, 1'b1, 3, 13, 13);
    run("glitch5", 12, 1'b1,  5, 1, 1'b0, 3,  8,  0);
    run("short10", 16, 1'b1, 10, 1, 1'b0, 3, 13,  0);
    run("gate",    36, 1'b1, 36, 3, 1'b0, 3, 33, 33);
    run("fall2",   16, 1'b0, 16, 1, 1'b1, 3, 13, 13);

    // Reset in the middle of a pending rise.
    run("rst_pre", 7, 1'b1, 7, 1, 1'b0, 3, 100, 0);
    @(posedge clk);
    #2;
    @(negedge clk);
    #1 reset = 1'b1;
    #1 check("rst_mid_async", {level, levelb, rise, fall, busy}, 5'b01000);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 check($sformatf("rst_hold_%0d", i), {level, levelb, rise, fall, busy}, 5'b01000);
    end
    @(posedge clk);
    #2 reset = 1'b0;
    run("rst_post", 16, 1'b1, 16, 1, 1'b0, 3, 13, 13);

    // Let the monitor drain; a non-empty queue means outputs were never checked.
    repeat (4) @(posedge clk);
    #3;
    tests++;
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
